// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS32 instruction-fetch front end.
package mips_fetch_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          ADDR_W    = 14;
  localparam int          BUF_DEPTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO of fetched {pc, inst, adel} entries; flush beats push and pop.
module fetch_buf
  import mips_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t mem [BUF_DEPTH];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         do_pop;

  assign head   = mem[rd_ptr];
  assign do_pop = pop && (count != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch front end: PC, one-cycle ROM reads, 2-entry buffer, redirects.
// Optional misaligned-redirect fault entries are built with FETCH_ALIGN_CHECK_EN.
module inst_fetch
  import mips_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_douta,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_inst,
  output logic              if_adel
);

  logic [31:0]  pc;
  logic [31:0]  infl_pc;
  logic         infl;
  logic [1:0]   count;
  logic         pop;
  logic         push;
  logic         credit;
  logic         halt;
  logic [31:0]  target;
  fetch_entry_t push_entry;
  fetch_entry_t head;

  // Handshake: an entry transfers on a rising edge where if_valid && if_ready;
  // the head holds stable until then, and a redirect drops it regardless.
  assign if_valid = (count != 2'd0);
  assign pop      = if_valid && if_ready;
  assign if_pc    = head.pc;
  assign if_inst  = head.inst;
  assign if_adel  = head.adel;

  // A slot is reserved for every read in flight so captures never overflow.
  assign credit   = ({1'b0, count} + {2'b00, infl} - {2'b00, pop}) < 3'd2;
  assign rom_en   = rst_n && !redirect_valid && !halt && credit;
  assign rom_addr = rst_n ? pc[ADDR_W+1:2] : '0;

`ifdef FETCH_ALIGN_CHECK_EN
  logic adel_pend;

  assign target = redirect_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt      <= 1'b0;
      adel_pend <= 1'b0;
    end else if (redirect_valid) begin
      halt      <= |redirect_pc[1:0];
      adel_pend <= |redirect_pc[1:0];
    end else begin
      adel_pend <= 1'b0;
    end
  end

  // pc already holds the faulting target in the cycle after the redirect.
  assign push       = !redirect_valid && (infl || adel_pend);
  assign push_entry = adel_pend ? '{pc: pc, inst: 32'h0, adel: 1'b1}
                                : '{pc: infl_pc, inst: rom_douta, adel: 1'b0};
`else
  assign halt       = 1'b0;
  assign target     = redirect_pc & 32'hFFFF_FFFC;
  assign push       = !redirect_valid && infl;
  assign push_entry = '{pc: infl_pc, inst: rom_douta, adel: 1'b0};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      infl    <= 1'b0;
      infl_pc <= 32'h0;
    end else if (redirect_valid) begin
      pc   <= target;
      infl <= 1'b0;
    end else begin
      if (rom_en) begin
        pc      <= pc + 32'd4;
        infl_pc <= pc;
      end
      infl <= rom_en;
    end
  end

  fetch_buf u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (push_entry),
    .head  (head),
    .count (count)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus randomized
// ready/redirect traffic checked against an in-order expected-stream scoreboard.
module tb_inst_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        rom_en;
  logic [13:0] rom_addr;
  logic [31:0] rom_douta;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_adel;

  logic [31:0] mem [16384];
  logic [64:0] exp_q [$];
  logic [31:0] gen_pc;
  logic        gen_live;
  int          test_cnt;
  int          fail_cnt;
  int          accepted;

  inst_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_en         (rom_en),
    .rom_addr       (rom_addr),
    .rom_douta      (rom_douta),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .if_adel        (if_adel)
  );

  // ---------------- clock / ROM model ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_douta <= rom_en ? mem[rom_addr] : 32'h0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  function automatic void sb_restart(input logic [31:0] t);
    exp_q.delete();
`ifdef FETCH_ALIGN_CHECK_EN
    if (t[1:0] != 2'b00) begin
      exp_q.push_back({t, 32'h0, 1'b1});
      gen_live = 1'b0;
      return;
    end
`endif
    gen_pc   = t & 32'hFFFF_FFFC;
    gen_live = 1'b1;
  endfunction

  always @(negedge clk) begin
    logic [64:0] e;
    if (!rst_n) begin
      sb_restart(RST_PC);
    end else if (redirect_valid) begin
      sb_restart(redirect_pc);
    end else if (if_valid && if_ready) begin
      if (exp_q.size() == 0 && gen_live) begin
        exp_q.push_back({gen_pc, mem[gen_pc[15:2]], 1'b0});
        gen_pc = gen_pc + 32'd4;
      end
      test_cnt++;
      accepted++;
      if (exp_q.size() == 0) begin
        fail_cnt++;
        $display("FAIL sb_accept: got pc=%h inst=%h adel=%b, required no entry", if_pc, if_inst, if_adel);
      end else begin
        e = exp_q.pop_front();
        if ({if_pc, if_inst, if_adel} !== e) begin
          fail_cnt++;
          $display("FAIL sb_entry: got pc=%h inst=%h adel=%b, required pc=%h inst=%h adel=%b",
                   if_pc, if_inst, if_adel, e[64:33], e[32:1], e[0]);
        end
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; if_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    test_cnt++;
    if ({rom_en, rom_addr, if_valid, if_pc, if_inst, if_adel} !== '0) begin
      fail_cnt++;
      $display("FAIL reset_outputs: got en=%b addr=%h v=%b pc=%h inst=%h adel=%b, required all 0",
               rom_en, rom_addr, if_valid, if_pc, if_inst, if_adel);
    end
    rst_n = 1'b1;
    #1;
    test_cnt++;
    if (rom_en !== 1'b1 || rom_addr !== RST_PC[15:2]) begin
      fail_cnt++;
      $display("FAIL reset_first_issue: got en=%b addr=%h, required en=1 addr=%h", rom_en, rom_addr, RST_PC[15:2]);
    end
  endtask

  task automatic test_stream();
    for (int k = 0; k < 12; k++) begin
      test_cnt++;
      if (rom_en !== 1'b1 || rom_addr !== 14'(k)) begin
        fail_cnt++;
        $display("FAIL stream_addr[%0d]: got en=%b addr=%h, required en=1 addr=%h", k, rom_en, rom_addr, 14'(k));
      end
      test_cnt++;
      if (k < 2) begin
        if (if_valid !== 1'b0) begin
          fail_cnt++;
          $display("FAIL stream_early_valid[%0d]: got %b, required 0", k, if_valid);
        end
      end else if (if_valid !== 1'b1 || if_pc !== 32'(4 * (k - 2)) || if_inst !== mem[k - 2]) begin
        fail_cnt++;
        $display("FAIL stream_head[%0d]: got v=%b pc=%h inst=%h, required v=1 pc=%h inst=%h",
                 k, if_valid, if_pc, if_inst, 32'(4 * (k - 2)), mem[k - 2]);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [31:0] hold_pc;
    logic [31:0] hold_inst;
    if_ready = 1'b0;
    #1;
    hold_pc = if_pc;
    hold_inst = if_inst;
    for (int s = 0; s < 5; s++) begin
      test_cnt++;
      if (rom_en !== 1'b0 || if_valid !== 1'b1 || if_pc !== hold_pc || if_inst !== hold_inst) begin
        fail_cnt++;
        $display("FAIL stall[%0d]: got en=%b v=%b pc=%h inst=%h, required en=0 v=1 pc=%h inst=%h",
                 s, rom_en, if_valid, if_pc, if_inst, hold_pc, hold_inst);
      end
      tick();
    end
    if_ready = 1'b1;
    #1;
    test_cnt++;
    if (rom_en !== 1'b1 || if_pc !== hold_pc) begin
      fail_cnt++;
      $display("FAIL stall_release: got en=%b pc=%h, required en=1 pc=%h", rom_en, if_pc, hold_pc);
    end
    repeat (6) tick();
  endtask

  task automatic test_redirect();
    if_ready = 1'b0;
    tick();
    tick();
    if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0180;
    #1;
    test_cnt++;
    if (rom_en !== 1'b0 || if_valid !== 1'b1) begin
      fail_cnt++;
      $display("FAIL redir_cycle: got en=%b v=%b, required en=0 v=1", rom_en, if_valid);
    end
    tick();
    redirect_valid = 1'b0;
    #1;
    test_cnt++;
    if (if_valid !== 1'b0 || rom_en !== 1'b1 || rom_addr !== 14'h60) begin
      fail_cnt++;
      $display("FAIL redir_t1: got v=%b en=%b addr=%h, required v=0 en=1 addr=060", if_valid, rom_en, rom_addr);
    end
    tick();
    test_cnt++;
    if (if_valid !== 1'b0) begin
      fail_cnt++;
      $display("FAIL redir_t2: got v=%b, required 0", if_valid);
    end
    tick();
    test_cnt++;
    if (if_valid !== 1'b1 || if_pc !== 32'h180 || if_inst !== mem[14'h60]) begin
      fail_cnt++;
      $display("FAIL redir_t3: got v=%b pc=%h inst=%h, required v=1 pc=00000180 inst=%h",
               if_valid, if_pc, if_inst, mem[14'h60]);
    end
    repeat (4) tick();
  endtask

  task automatic test_wrap();
    logic [13:0] exp_addr [3];
    logic [31:0] exp_pc [3];
    exp_addr[0] = 14'h3FFE; exp_addr[1] = 14'h3FFF; exp_addr[2] = 14'h0000;
    exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0000_0000;
    if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      #1;
      if (k <= 3) begin
        test_cnt++;
        if (rom_en !== 1'b1 || rom_addr !== exp_addr[k - 1]) begin
          fail_cnt++;
          $display("FAIL wrap_addr[%0d]: got en=%b addr=%h, required en=1 addr=%h", k, rom_en, rom_addr, exp_addr[k - 1]);
        end
      end
      if (k >= 3) begin
        test_cnt++;
        if (if_valid !== 1'b1 || if_pc !== exp_pc[k - 3] || if_inst !== mem[exp_pc[k - 3][15:2]]) begin
          fail_cnt++;
          $display("FAIL wrap_pc[%0d]: got v=%b pc=%h inst=%h, required v=1 pc=%h", k, if_valid, if_pc, if_inst, exp_pc[k - 3]);
        end
      end
      tick();
    end
  endtask

  task automatic test_align();
    if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
    tick();
    redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    #1;
    test_cnt++;
    if (rom_en !== 1'b0 || if_valid !== 1'b0) begin
      fail_cnt++;
      $display("FAIL align_t1: got en=%b v=%b, required en=0 v=0", rom_en, if_valid);
    end
    tick();
    test_cnt++;
    if (if_valid !== 1'b1 || if_adel !== 1'b1 || if_pc !== 32'h102 || if_inst !== 32'h0 || rom_en !== 1'b0) begin
      fail_cnt++;
      $display("FAIL align_fault: got v=%b adel=%b pc=%h inst=%h en=%b, required v=1 adel=1 pc=00000102 inst=0 en=0",
               if_valid, if_adel, if_pc, if_inst, rom_en);
    end
    tick();
    for (int k = 0; k < 4; k++) begin
      test_cnt++;
      if (rom_en !== 1'b0 || if_valid !== 1'b0) begin
        fail_cnt++;
        $display("FAIL align_halt[%0d]: got en=%b v=%b, required en=0 v=0", k, rom_en, if_valid);
      end
      tick();
    end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    #1;
    test_cnt++;
    if (rom_en !== 1'b1 || rom_addr !== 14'h40) begin
      fail_cnt++;
      $display("FAIL align_resume: got en=%b addr=%h, required en=1 addr=040", rom_en, rom_addr);
    end
    repeat (4) tick();
`else
    #1;
    test_cnt++;
    if (rom_en !== 1'b1 || rom_addr !== 14'h40) begin
      fail_cnt++;
      $display("FAIL align_forced_addr: got en=%b addr=%h, required en=1 addr=040", rom_en, rom_addr);
    end
    tick();
    tick();
    test_cnt++;
    if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_adel !== 1'b0 || if_inst !== mem[14'h40]) begin
      fail_cnt++;
      $display("FAIL align_forced_head: got v=%b pc=%h adel=%b inst=%h, required v=1 pc=00000100 adel=0 inst=%h",
               if_valid, if_pc, if_adel, if_inst, mem[14'h40]);
    end
    repeat (3) tick();
`endif
  endtask

  task automatic test_random();
    int start;
    start = accepted;
    for (int c = 0; c < 3000; c++) begin
      if_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 39) == 0);
      redirect_pc = $urandom;
`ifdef FETCH_ALIGN_CHECK_EN
      if ($urandom_range(0, 3) != 0) redirect_pc = redirect_pc & 32'hFFFF_FFFC;
`endif
      tick();
    end
    redirect_valid = 1'b0;
    if_ready = 1'b1;
    repeat (4) tick();
    test_cnt++;
    if (accepted - start < 500) begin
      fail_cnt++;
      $display("FAIL random_progress: got %0d accepted, required at least 500", accepted - start);
    end
  endtask

  task automatic test_reset_mid();
    if_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_2000;
    tick();
    redirect_valid = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    test_cnt++;
    if ({rom_en, rom_addr, if_valid, if_pc, if_inst, if_adel} !== '0) begin
      fail_cnt++;
      $display("FAIL reset_mid_async: got en=%b addr=%h v=%b pc=%h inst=%h adel=%b, required all 0",
               rom_en, rom_addr, if_valid, if_pc, if_inst, if_adel);
    end
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    test_cnt++;
    if (rom_en !== 1'b1 || rom_addr !== RST_PC[15:2]) begin
      fail_cnt++;
      $display("FAIL reset_mid_restart: got en=%b addr=%h, required en=1 addr=%h", rom_en, rom_addr, RST_PC[15:2]);
    end
    tick();
    tick();
    test_cnt++;
    if (if_valid !== 1'b1 || if_pc !== RST_PC || if_inst !== mem[RST_PC[15:2]]) begin
      fail_cnt++;
      $display("FAIL reset_mid_head: got v=%b pc=%h inst=%h, required v=1 pc=%h inst=%h",
               if_valid, if_pc, if_inst, RST_PC, mem[RST_PC[15:2]]);
    end
    repeat (6) tick();
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_cnt = 0;
    fail_cnt = 0;
    accepted = 0;
    gen_pc = RST_PC;
    gen_live = 1'b1;
    rst_n = 1'b0;
    if_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    for (int i = 0; i < 16384; i++) mem[i] = $urandom;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_align();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
